// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, immediate-select codes, the decoded
// pipeline entry and the FSM state type of the IF/ID skid buffer.
package riscv_pkg;

    localparam int RV_XLEN  = 32;
    localparam int RV_IMM_W = 20;

    // RV32I base opcodes
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] MISC_MEM = 7'b0001111;

    // Immediate-generator select codes (B and J are shifted left by the generator)
    localparam logic [1:0] IMM_I_S = 2'd0;
    localparam logic [1:0] IMM_B   = 2'd1;
    localparam logic [1:0] IMM_U   = 2'd2;
    localparam logic [1:0] IMM_J   = 2'd3;

    typedef struct packed {
        logic [RV_XLEN-1:0]  pc;
        logic [RV_XLEN-1:0]  instr;
        logic [RV_IMM_W-1:0] imm_field;
        logic [1:0]          imm_sel;
        logic                illegal;
    } dec_entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/imm_field_pack.sv
// Packs the raw immediate bits of an RV32I instruction into the 20-bit
// field and 2-bit select code expected by the immediate generator.
module imm_field_pack
    import riscv_pkg::*;
(
    input  logic [RV_XLEN-1:0]  i_instr,
    output logic [RV_IMM_W-1:0] o_imm_field,
    output logic [1:0]          o_imm_sel,
    output logic                o_illegal
);

    logic [6:0] w_opcode;
    assign w_opcode = i_instr[6:0];

    // Opcode-driven immediate packing; unknown opcodes flag illegal with a zero field
    always_comb begin
        o_imm_field = 20'd0;
        o_imm_sel   = IMM_I_S;
        o_illegal   = 1'b0;
        case (w_opcode)
            OP_IMM, LOAD, JALR, SYSTEM: begin
                o_imm_field = {8'd0, i_instr[31:20]};
            end
            STORE: begin
                o_imm_field = {8'd0, i_instr[31:25], i_instr[11:7]};
            end
            BRANCH: begin
                o_imm_field = {8'd0, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8]};
                o_imm_sel   = IMM_B;
            end
            LUI, AUIPC: begin
                o_imm_field = i_instr[31:12];
                o_imm_sel   = IMM_U;
            end
            JAL: begin
                o_imm_field = {i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21]};
                o_imm_sel   = IMM_J;
            end
            OP, MISC_MEM: begin
                o_imm_field = 20'd0;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/if_id_decode_stage.sv
// IF/ID stage: accepts {pc, instr} from fetch, pre-decodes it and holds it in
// a 2-entry skid buffer (main output register + overflow register) so that
// in_ready is fully registered and never depends on out_ready.
module if_id_decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = RV_XLEN,
    parameter int IMM_W = RV_IMM_W
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_instr,
    output logic [6:0]       out_opcode,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [IMM_W-1:0] out_imm_field,
    output logic [1:0]       out_imm_sel,
    output logic             out_illegal
);

    logic [IMM_W-1:0] w_imm_field;
    logic [1:0]       w_imm_sel;
    logic             w_illegal;
    dec_entry_t       w_new_entry;
    logic             w_accept;
    logic             w_consume;

    buf_state_e       r_state;
    dec_entry_t       r_main;
    dec_entry_t       r_skid;
    logic             r_out_valid;
    logic             r_in_ready;

    imm_field_pack u_imm_field_pack (
        .i_instr     (in_instr),
        .o_imm_field (w_imm_field),
        .o_imm_sel   (w_imm_sel),
        .o_illegal   (w_illegal)
    );

    assign w_accept  = in_valid && r_in_ready;
    assign w_consume = r_out_valid && out_ready;

    // Assemble the decoded entry that is captured on an accepted transfer
    always_comb begin
        w_new_entry           = '0;
        w_new_entry.pc        = in_pc;
        w_new_entry.instr     = in_instr;
        w_new_entry.imm_field = w_imm_field;
        w_new_entry.imm_sel   = w_imm_sel;
        w_new_entry.illegal   = w_illegal;
    end

    // Skid-buffer FSM; flush only clears valid, payload may stay stale
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_main      <= w_new_entry;
                        r_state     <= ST_ONE;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_consume) begin
                        r_main <= w_new_entry;
                    end else if (w_accept) begin
                        r_skid     <= w_new_entry;
                        r_state    <= ST_FULL;
                        r_in_ready <= 1'b0;
                    end else if (w_consume) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so no new entry can arrive
                    if (w_consume) begin
                        r_main     <= r_skid;
                        r_state    <= ST_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign out_pc        = r_main.pc;
    assign out_instr     = r_main.instr;
    assign out_opcode    = r_main.instr[6:0];
    assign out_rd        = r_main.instr[11:7];
    assign out_funct3    = r_main.instr[14:12];
    assign out_rs1       = r_main.instr[19:15];
    assign out_rs2       = r_main.instr[24:20];
    assign out_imm_field = r_main.imm_field;
    assign out_imm_sel   = r_main.imm_sel;
    assign out_illegal   = r_main.illegal;

endmodule

// File: tb/tb_if_id_decode_stage.sv
// Bench for if_id_decode_stage: directed test-plan steps followed by random
// traffic, compared against a queue-based 2-deep buffer model and an
// immediate model built from the architectural immediate values.
module tb_if_id_decode_stage;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [2:0]  out_funct3;
    logic [19:0] out_imm_field;
    logic [1:0]  out_imm_sel;
    logic        out_illegal;

    int total;
    int bad;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t q[$];
    logic exp_rdy;

    if_id_decode_stage dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_instr      (in_instr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_instr     (out_instr),
        .out_opcode    (out_opcode),
        .out_rd        (out_rd),
        .out_rs1       (out_rs1),
        .out_rs2       (out_rs2),
        .out_funct3    (out_funct3),
        .out_imm_field (out_imm_field),
        .out_imm_sel   (out_imm_sel),
        .out_illegal   (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode: build the architectural immediate value, then take
    // the bits the generator expects (it re-adds the shift for B/J).
    task automatic ref_decode(input logic [31:0] ins, output logic [19:0] f,
                              output logic [1:0] s, output logic il);
        logic [31:0] imm;
        logic [6:0]  opc;
        opc = ins[6:0];
        f   = 20'd0;
        s   = 2'd0;
        il  = 1'b0;
        imm = 32'd0;
        case (opc)
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                imm = {{20{ins[31]}}, ins[31:20]};
                f   = {8'd0, imm[11:0]};
            end
            7'b0100011: begin
                imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                f   = {8'd0, imm[11:0]};
            end
            7'b1100011: begin
                imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                f   = {8'd0, imm[12:1]};
                s   = 2'd1;
            end
            7'b0110111, 7'b0010111: begin
                imm = {ins[31:12], 12'd0};
                f   = imm[31:12];
                s   = 2'd2;
            end
            7'b1101111: begin
                imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                f   = imm[20:1];
                s   = 2'd3;
            end
            7'b0110011, 7'b0001111: begin
                f = 20'd0;
            end
            default: il = 1'b1;
        endcase
    endtask

    task automatic check_all();
        logic [19:0] f;
        logic [1:0]  s;
        logic        il;
        logic [31:0] ins;
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        chk("out_valid", {31'd0, out_valid}, (q.size() > 0) ? 32'd1 : 32'd0);
        if (q.size() > 0) begin
            ins = q[0].instr;
            ref_decode(ins, f, s, il);
            chk("out_pc", out_pc, q[0].pc);
            chk("out_instr", out_instr, ins);
            chk("out_opcode", {25'd0, out_opcode}, {25'd0, ins[6:0]});
            chk("out_rd", {27'd0, out_rd}, {27'd0, ins[11:7]});
            chk("out_funct3", {29'd0, out_funct3}, {29'd0, ins[14:12]});
            chk("out_rs1", {27'd0, out_rs1}, {27'd0, ins[19:15]});
            chk("out_rs2", {27'd0, out_rs2}, {27'd0, ins[24:20]});
            chk("out_imm_field", {12'd0, out_imm_field}, {12'd0, f});
            chk("out_imm_sel", {30'd0, out_imm_sel}, {30'd0, s});
            chk("out_illegal", {31'd0, out_illegal}, {31'd0, il});
        end
    endtask

    // One clock of stimulus; the model advances on the same edge as the DUT
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl);
        logic acc;
        logic con;
        ent_t e;
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        acc = v && exp_rdy;
        con = (q.size() > 0) && ordy;
        if (fl) begin
            q.delete();
        end else begin
            if (con) q.delete(0);
            if (acc) begin
                e.pc    = pc;
                e.instr = ins;
                q.push_back(e);
            end
        end
        exp_rdy = (q.size() < 2);
        #1;
        check_all();
    endtask

    logic [6:0] opc_tbl [12];

    initial begin
        logic [31:0] r;
        logic [6:0]  opc;
        total     = 0;
        bad       = 0;
        exp_rdy   = 1'b1;
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = 32'd0;
        in_instr  = 32'd0;
        out_ready = 1'b0;
        opc_tbl = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0100011, 7'b1100011,
                    7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0001111, 7'b0000000};

        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_imm_field", {12'd0, out_imm_field}, 32'd0);
        chk("rst_illegal", {31'd0, out_illegal}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // basic decode, streaming with out_ready=1
        step(1'b1, 32'h100, 32'hFFF00093, 1'b1, 1'b0);
        chk("addi_valid", {31'd0, out_valid}, 32'd1);
        chk("addi_imm", {12'd0, out_imm_field}, 32'h00FFF);
        chk("addi_sel", {30'd0, out_imm_sel}, 32'd0);
        chk("addi_rd", {27'd0, out_rd}, 32'd1);
        chk("addi_rs1", {27'd0, out_rs1}, 32'd0);
        step(1'b1, 32'h104, 32'h0020A423, 1'b1, 1'b0);
        chk("sw_imm", {12'd0, out_imm_field}, 32'h00008);
        chk("sw_rs1", {27'd0, out_rs1}, 32'd1);
        chk("sw_rs2", {27'd0, out_rs2}, 32'd2);
        step(1'b1, 32'h108, 32'hFE000EE3, 1'b1, 1'b0);
        chk("beq_imm", {12'd0, out_imm_field}, 32'h00FFE);
        chk("beq_sel", {30'd0, out_imm_sel}, 32'd1);
        step(1'b1, 32'h10C, 32'h123452B7, 1'b1, 1'b0);
        chk("lui_imm", {12'd0, out_imm_field}, 32'h12345);
        chk("lui_sel", {30'd0, out_imm_sel}, 32'd2);
        chk("lui_rd", {27'd0, out_rd}, 32'd5);
        step(1'b1, 32'h110, 32'h001000EF, 1'b1, 1'b0);
        chk("jal_imm", {12'd0, out_imm_field}, 32'h00400);
        chk("jal_sel", {30'd0, out_imm_sel}, 32'd3);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("drain_valid", {31'd0, out_valid}, 32'd0);

        // back-pressure fills both entries, then release
        step(1'b1, 32'h200, 32'hFFF00093, 1'b0, 1'b0);
        step(1'b1, 32'h204, 32'h0020A423, 1'b0, 1'b0);
        chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_pc", out_pc, 32'h200);
        step(1'b1, 32'h208, 32'hFE000EE3, 1'b0, 1'b0);
        chk("bp_hold_pc2", out_pc, 32'h200);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("bp_second_pc", out_pc, 32'h204);
        chk("bp_ready_high", {31'd0, in_ready}, 32'd1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // flush while full with a concurrent input
        step(1'b1, 32'h300, 32'hFFF00093, 1'b0, 1'b0);
        step(1'b1, 32'h304, 32'h0020A423, 1'b0, 1'b0);
        step(1'b1, 32'h308, 32'h123452B7, 1'b0, 1'b1);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_ready", {31'd0, in_ready}, 32'd1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("flush_nothing", {31'd0, out_valid}, 32'd0);

        // illegal opcode still flows
        step(1'b1, 32'h400, 32'h0000007F, 1'b0, 1'b0);
        chk("ill_valid", {31'd0, out_valid}, 32'd1);
        chk("ill_flag", {31'd0, out_illegal}, 32'd1);
        chk("ill_imm", {12'd0, out_imm_field}, 32'd0);
        chk("ill_sel", {30'd0, out_imm_sel}, 32'd0);

        // asynchronous reset while holding one entry
        reset = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_pc", out_pc, 32'd0);
        chk("arst_illegal", {31'd0, out_illegal}, 32'd0);
        q.delete();
        exp_rdy = 1'b1;
        #1;
        reset = 1'b1;

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            r   = $urandom();
            opc = opc_tbl[$urandom_range(0, 11)];
            if (opc == 7'b0000000) opc = r[6:0];
            step(($urandom_range(0, 3) != 0), $urandom(), {r[31:7], opc},
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
